// File: rtl/countdown_seconds.sv
// Seconds countdown timer: loads SW on a LOAD press, counts down once per TICK_DIV cycles to zero.
// Optional: define COUNTDOWN_DONE_BLINK_EN to blink the LEDs while in DONE.
module countdown_seconds #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  input  logic             BTN_LOAD,
  input  logic             BTN_START,
  input  logic             BTN_PAUSE,
  output logic [WIDTH-1:0] LED,
  output logic             DONE,
  output logic             RUNNING
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d, presc_next;
  logic             btn_load_q, btn_start_q, btn_pause_q;
  logic             armed_q;
  logic             press_load, press_start, press_pause;
  logic             presc_en, tick;
`ifdef COUNTDOWN_DONE_BLINK_EN
  logic             blink_q, blink_d;
`endif

  // armed_q masks the first cycle after reset so a button held across reset release is not a press.
  assign press_load  = BTN_LOAD  & ~btn_load_q  & armed_q;
  assign press_start = BTN_START & ~btn_start_q & armed_q;
  assign press_pause = BTN_PAUSE & ~btn_pause_q & armed_q;

`ifdef COUNTDOWN_DONE_BLINK_EN
  assign presc_en = (state_q == S_RUN) || (state_q == S_DONE);
`else
  assign presc_en = (state_q == S_RUN);
`endif
  assign tick       = presc_en && (presc_q == PRESC_LAST);
  assign presc_next = tick ? '0 : presc_q + PW'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
`ifdef COUNTDOWN_DONE_BLINK_EN
    blink_d = blink_q;
`endif
    if (press_load) begin
      // LOAD wins over any same-cycle START/PAUSE press or tick.
      state_d = S_IDLE;
      count_d = SW;
      presc_d = '0;
`ifdef COUNTDOWN_DONE_BLINK_EN
      blink_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (press_start) begin
            presc_d = '0;
            if (count_q != '0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
`ifdef COUNTDOWN_DONE_BLINK_EN
              blink_d = 1'b1;
`endif
            end
          end
        end
        S_RUN: begin
          presc_d = presc_next;
          if (tick && (count_q <= WIDTH'(1))) begin
            count_d = '0;
            state_d = S_DONE;
`ifdef COUNTDOWN_DONE_BLINK_EN
            blink_d = 1'b1;
`endif
          end else begin
            if (tick) count_d = count_q - WIDTH'(1);
            if (press_pause) state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (press_start || press_pause) state_d = S_RUN;
        end
        S_DONE: begin
          count_d = '0;
`ifdef COUNTDOWN_DONE_BLINK_EN
          presc_d = presc_next;
          blink_d = blink_q ^ tick;
`else
          presc_d = '0;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      presc_q     <= '0;
      btn_load_q  <= 1'b0;
      btn_start_q <= 1'b0;
      btn_pause_q <= 1'b0;
      armed_q     <= 1'b0;
`ifdef COUNTDOWN_DONE_BLINK_EN
      blink_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      btn_load_q  <= BTN_LOAD;
      btn_start_q <= BTN_START;
      btn_pause_q <= BTN_PAUSE;
      armed_q     <= 1'b1;
`ifdef COUNTDOWN_DONE_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

`ifdef COUNTDOWN_DONE_BLINK_EN
  assign LED = (state_q == S_DONE) ? {WIDTH{blink_q}} : count_q;
`else
  assign LED = count_q;
`endif
  assign DONE    = (state_q == S_DONE);
  assign RUNNING = (state_q == S_RUN);

endmodule

// File: tb/tb_countdown_seconds.sv
// Self-checking bench for countdown_seconds (TICK_DIV=4): cycle model of elapsed run time plus directed checks.
module tb_countdown_seconds;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
`ifdef COUNTDOWN_DONE_BLINK_EN
  localparam logic [7:0] DONE_ON  = 8'hFF;
  localparam logic [7:0] DONE_OFF = 8'h00;
`else
  localparam logic [7:0] DONE_ON  = 8'h00;
  localparam logic [7:0] DONE_OFF = 8'h00;
`endif

  logic       CLK100MHZ = 1'b0;
  logic       RST;
  logic [7:0] SW;
  logic       BTN_LOAD, BTN_START, BTN_PAUSE;
  logic [7:0] LED;
  logic       DONE, RUNNING;

  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 1'b0;

  countdown_seconds #(.TICK_DIV(TD), .WIDTH(8)) dut (
    .CLK100MHZ(CLK100MHZ), .RST(RST), .SW(SW),
    .BTN_LOAD(BTN_LOAD), .BTN_START(BTN_START), .BTN_PAUSE(BTN_PAUSE),
    .LED(LED), .DONE(DONE), .RUNNING(RUNNING)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the count is the loaded value minus whole seconds of accumulated run time.
  int   m_load = 0, m_run = 0, m_done_cyc = 0, m_mode = M_IDLE;
  logic m_prev_l = 1'b0, m_prev_s = 1'b0, m_prev_p = 1'b0;
  logic m_pl, m_ps, m_pp;

  always @(posedge CLK100MHZ) begin
    m_pl = BTN_LOAD  & ~m_prev_l;
    m_ps = BTN_START & ~m_prev_s;
    m_pp = BTN_PAUSE & ~m_prev_p;
    if (RST) begin
      m_load = 0; m_run = 0; m_done_cyc = 0; m_mode = M_IDLE;
    end else if (m_pl) begin
      m_load = int'(SW); m_run = 0; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (m_ps) begin
          if (m_load == 0) begin m_mode = M_DONE; m_done_cyc = 0; end
          else m_mode = M_RUN;
        end
        M_RUN: begin
          m_run++;
          if (m_run / TD >= m_load) begin m_mode = M_DONE; m_done_cyc = 0; end
          else if (m_pp) m_mode = M_PAUSED;
        end
        M_PAUSED: if (m_ps || m_pp) m_mode = M_RUN;
        default: m_done_cyc++;
      endcase
    end
    m_prev_l = BTN_LOAD;
    m_prev_s = BTN_START;
    m_prev_p = BTN_PAUSE;
  end

  always @(negedge CLK100MHZ) begin
    logic [7:0] exp_led;
    if (cmp_en) begin
      if (m_mode == M_DONE) exp_led = ((m_done_cyc / TD) % 2 == 0) ? DONE_ON : DONE_OFF;
      else                  exp_led = 8'(m_load - m_run / TD);
      check("model_led", 32'(LED), 32'(exp_led));
      check("model_done", 32'(DONE), 32'(m_mode == M_DONE));
      check("model_running", 32'(RUNNING), 32'(m_mode == M_RUN));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  // Drive the given buttons for exactly one cycle; returns just after the edge that saw them.
  task automatic press(input logic l, input logic s, input logic p);
    BTN_LOAD = l; BTN_START = s; BTN_PAUSE = p;
    @(negedge CLK100MHZ);
    BTN_LOAD = 1'b0; BTN_START = 1'b0; BTN_PAUSE = 1'b0;
  endtask

  initial begin
    RST = 1'b1; SW = 8'h00; BTN_LOAD = 1'b0; BTN_START = 1'b0; BTN_PAUSE = 1'b0;

    // Reset with buttons toggling; START held across release.
    cyc(1); BTN_LOAD = 1'b1; SW = 8'hAA;
    cyc(1); BTN_LOAD = 1'b0; BTN_START = 1'b1; BTN_PAUSE = 1'b1;
    cyc(1); BTN_PAUSE = 1'b0; RST = 1'b0; cmp_en = 1'b1;
    cyc(2);
    check("reset_led", 32'(LED), 32'h0);
    check("reset_done", 32'(DONE), 32'h0);
    check("reset_running", 32'(RUNNING), 32'h0);
    BTN_START = 1'b0;
    cyc(1);

    // Count 3 down to 0, then blink/hold in DONE.
    SW = 8'd3; press(1, 0, 0);
    press(0, 1, 0);
    check("run3_running", 32'(RUNNING), 32'h1);
    check("run3_led_e0", 32'(LED), 32'd3);
    cyc(3); check("run3_led_e3", 32'(LED), 32'd3);
    cyc(1); check("run3_led_e4", 32'(LED), 32'd2);
    cyc(4); check("run3_led_e8", 32'(LED), 32'd1);
    cyc(4); check("run3_led_e12", 32'(LED), 32'(DONE_ON));
    check("run3_done_e12", 32'(DONE), 32'h1);
    check("run3_running_e12", 32'(RUNNING), 32'h0);
    cyc(3); check("done_led_e15", 32'(LED), 32'(DONE_ON));
    cyc(1); check("done_led_e16", 32'(LED), 32'(DONE_OFF));
    cyc(4); check("done_led_e20", 32'(LED), 32'(DONE_ON));
    press(0, 1, 1);
    check("done_ignores_start", 32'(DONE), 32'h1);
    SW = 8'd2; press(1, 0, 0);
    check("load_exit_done_led", 32'(LED), 32'd2);
    check("load_exit_done_done", 32'(DONE), 32'h0);
    cyc(8); check("idle_holds", 32'(LED), 32'd2);

    // Pause preserves the partial second.
    SW = 8'd5; press(1, 0, 0);
    press(0, 1, 0);
    cyc(4); check("pause_first_dec", 32'(LED), 32'd4);
    cyc(1); press(0, 0, 1);
    check("paused_running", 32'(RUNNING), 32'h0);
    cyc(20);
    check("paused_led_hold", 32'(LED), 32'd4);
    check("paused_running_hold", 32'(RUNNING), 32'h0);
    press(0, 1, 0);
    check("resume_running", 32'(RUNNING), 32'h1);
    cyc(1); check("resume_led_p1", 32'(LED), 32'd4);
    cyc(1); check("resume_led_p2", 32'(LED), 32'd3);
    cyc(16); check("pause_run_done", 32'(DONE), 32'h1);

    // Zero preset: PAUSE ignored in IDLE, START goes straight to DONE.
    SW = 8'd0; press(1, 0, 0);
    press(0, 0, 1);
    check("idle_pause_ignored", 32'(RUNNING), 32'h0);
    press(0, 1, 0);
    check("zero_done", 32'(DONE), 32'h1);
    check("zero_led", 32'(LED), 32'(DONE_ON));
    check("zero_running", 32'(RUNNING), 32'h0);

    // LOAD coincident with a tick and a PAUSE edge.
    SW = 8'd7; press(1, 0, 0);
    press(0, 1, 0);
    cyc(4); check("pre_load_led", 32'(LED), 32'd6);
    cyc(3); SW = 8'd9; press(1, 0, 1);
    check("load_tick_led", 32'(LED), 32'd9);
    check("load_tick_running", 32'(RUNNING), 32'h0);
    check("load_tick_done", 32'(DONE), 32'h0);
    press(0, 1, 0);
    cyc(3); check("reload_led_e3", 32'(LED), 32'd9);
    cyc(1); check("reload_led_e4", 32'(LED), 32'd8);

    // Held simultaneous START+PAUSE: one press each time.
    SW = 8'd10; press(1, 0, 0);
    press(0, 1, 0);
    cyc(2);
    BTN_START = 1'b1; BTN_PAUSE = 1'b1;
    cyc(6); check("held_pause_once", 32'(RUNNING), 32'h0);
    BTN_START = 1'b0; BTN_PAUSE = 1'b0;
    cyc(2); press(0, 1, 1);
    check("paused_both_resume", 32'(RUNNING), 32'h1);
    cyc(45); check("long_run_done", 32'(DONE), 32'h1);

    // Reset mid-count, coincident with a tick.
    SW = 8'd4; press(1, 0, 0);
    press(0, 1, 0);
    cyc(3); RST = 1'b1;
    cyc(1); RST = 1'b0;
    check("midreset_led", 32'(LED), 32'h0);
    check("midreset_running", 32'(RUNNING), 32'h0);
    cyc(4);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_seconds.md
Name: countdown_seconds

Overview:
- Seconds countdown timer for the board: loads an 8-bit value from the slide switches and counts down once per second to zero, showing the live value on the LEDs.
- Inverse of the existing count-up seconds display.
- Uses an internal prescaler that produces a one-cycle tick enable. It does not derive a new clock, so the whole block runs in the CLK100MHZ domain.
- Buttons arrive already synchronized and debounced; the block edge-detects them internally.

Parameters:
- TICK_DIV, 100_000_000: CLK100MHZ cycles per count step. Must be >= 2. Set to 4 in simulation.
- WIDTH, 8: width of the count, the switch input and the LED output.

Ports:
- CLK100MHZ  input  1  system clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- SW  input  WIDTH  preset value, sampled on a LOAD press.
- BTN_LOAD  input  1  level; a rising edge loads SW.
- BTN_START  input  1  level; a rising edge starts or resumes counting.
- BTN_PAUSE  input  1  level; a rising edge pauses while running.
- LED  output  WIDTH  current count (blink pattern in DONE when the optional feature is compiled in).
- DONE  output  1  high while in DONE state.
- RUNNING  output  1  high while in RUN state.

Behaviour:
- Interface: one clock, CLK100MHZ. Reset RST is synchronous and active-high.
- Reset values:
  - state = IDLE, count = 0, prescaler = 0.
  - Button history registers = 0.
  - LED = 0, DONE = 0, RUNNING = 0.
- Reset mid-count aborts immediately; no tick is delivered in the reset cycle.
- Edge detect: press_x = BTN_x & ~BTN_x_q, with BTN_x_q registered every cycle. A press acts in the cycle its rising edge is seen. A held button produces exactly one press.
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - Increments only in RUN (and in DONE when the optional feature is on).
  - At TICK_DIV-1 it wraps to 0 and asserts tick for that single cycle.
- State IDLE:
  - Count holds.
  - START press with count != 0: go to RUN, prescaler = 0.
  - START press with count == 0: go to DONE next cycle.
  - PAUSE press: ignored.
- State RUN:
  - On tick with count > 1: count = count - 1.
  - On tick with count == 1: count = 0 and state = DONE in the same cycle.
  - PAUSE press: go to PAUSED; prescaler holds its value.
  - START press: ignored.
- State PAUSED:
  - Count and prescaler hold.
  - START or PAUSE press: return to RUN; the prescaler resumes from its held value, so the partial second is preserved.
- State DONE:
  - count = 0, DONE = 1.
  - START and PAUSE presses: ignored.
  - Only LOAD or RST exits.
- LOAD press in any state:
  - count = SW, prescaler = 0, state = IDLE.
  - LOAD has priority over a simultaneous START/PAUSE press and over a same-cycle tick.
- Simultaneous START and PAUSE presses: only the press valid for the current state acts (PAUSE in RUN; START in IDLE/PAUSED). No conflict is possible.
- No wrap-around: count never decrements below 0.
- Outputs:
  - RUNNING = (state == RUN).
  - DONE = (state == DONE).
  - LED = count (all states except as noted under Optional Feature).
  - All outputs are driven from registers with no combinational input-to-output path.
- Latency:
  - Button edge to state change: 1 cycle.
  - RUN entry to first decrement: exactly TICK_DIV cycles.

Optional Feature:
- Macro: COUNTDOWN_DONE_BLINK_EN.
- Defined:
  - In DONE the prescaler keeps running.
  - A blink register is set to 1 on DONE entry and toggles on every tick.
  - LED = {WIDTH{blink}}: all on, then all off, alternating every TICK_DIV cycles.
  - LOAD or RST clears blink.
- Undefined: no blink register; in DONE, LED = 0 and the prescaler holds at 0.

Test Plan (TICK_DIV=4):
- RST held 2 cycles with buttons toggling -> LED=0, DONE=0, RUNNING=0. A button held high across reset release gives no press.
- SW=3, LOAD, then START -> RUNNING=1. LED reads 3, then 2, 1, 0 at 4, 8 and 12 cycles after the START edge. DONE=1 in the same cycle LED=0. A further START leaves DONE=1.
- SW=5, START; PAUSE 2 cycles after the first decrement (LED=4); hold 20 cycles -> LED stays 4, RUNNING=0. START -> LED=3 exactly 2 cycles later.
- SW=0, LOAD, START -> DONE=1 on the next cycle, LED=0, RUNNING=0.
- RUN with LED=6; LOAD with SW=9 coincident with a tick and a PAUSE edge -> LED=9, state IDLE, no decrement. The next START gives 8 after 4 cycles.
- With COUNTDOWN_DONE_BLINK_EN: after reaching 0 -> LED=8'hFF, then 8'h00 every 4 cycles, repeating. LOAD SW=2 -> LED=2, blink stops. Without the macro -> LED stays 8'h00.
